// File: rtl/mem_bist_arbiter.sv
// mem_bist_arbiter: shares the single-port TMemory between the functional host
// port and BIST_FSM, and sequences BIST sessions
// (IDLE -> DRAIN -> BIST -> RELEASE).
module mem_bist_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  // host port
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  // session control
  input  logic              bist_req,
  input  logic [ADDR_W-1:0] bist_start_addr,
  input  logic [ADDR_W-1:0] bist_end_addr,
  input  logic [LEN_W-1:0]  bist_len,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_err,
  // BIST_FSM side
  output logic              runbist_en,
  output logic              idle_en,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] end_addr,
  input  logic              bist_read_mem,
  input  logic [ADDR_W-1:0] bist_mem_addr,
  // TMemory side
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_BIST    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_start;
  logic [ADDR_W-1:0]   r_end;
  logic                r_done;
  logic                r_err;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_accept;
  logic                w_reject;
  logic                w_last;
  logic [LEN_W-1:0]    w_len_eff;

  // A zero run length still gives one BIST cycle
  assign w_len_eff = (bist_len == '0) ? LEN_W'(1) : bist_len;

  // Next-state decode plus memory-port ownership mux
  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_reject       = 1'b0;
    w_last         = 1'b0;
    host_gnt       = 1'b0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (r_state)
      S_IDLE: begin
        host_gnt       = host_req;
        mem_write_en   = host_req & host_we;
        mem_read_en    = host_req & ~host_we;
        mem_addr       = host_addr;
        mem_write_data = host_wdata;
        if (bist_req) begin
          if (bist_start_addr <= bist_end_addr) begin
            w_accept = 1'b1;
            w_next   = S_DRAIN;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        w_next = S_BIST;
      end
      S_BIST: begin
        mem_read_en = bist_read_mem;
        mem_addr    = bist_mem_addr;
        // <= rather than == so a corrupted zero count cannot wrap into a long run
        if (r_cnt <= LEN_W'(1)) begin
          w_last = 1'b1;
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Window latch and run-length counter, frozen once a session is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_start <= '0;
      r_end   <= '0;
    end else if (w_accept) begin
      r_cnt   <= w_len_eff;
      r_start <= bist_start_addr;
      r_end   <= bist_end_addr;
    end else if (r_state == S_BIST) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  // Completion pulse: high during RELEASE, or the cycle after a rejected request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_reject | w_last;
      r_err  <= w_reject;
    end
  end

  // Host read return tracking; BIST reads never mark a host return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= host_gnt & ~host_we;
      if (r_rvalid) begin
        r_rdata <= mem_read_data;
      end
    end
  end

  // The memory already registers its read data, so the return cycle passes it
  // through; r_rdata holds the last host read data afterwards and ignores BIST reads.
  assign host_rdata  = r_rvalid ? mem_read_data : r_rdata;
  assign host_rvalid = r_rvalid;

  assign runbist_en  = (r_state == S_BIST);
  assign idle_en     = (r_state == S_BIST);
  assign bist_busy   = (r_state != S_IDLE);
  assign bist_done   = r_done;
  assign bist_err    = r_err;
  assign start_addr  = r_start;
  assign end_addr    = r_end;

endmodule

// File: tb/tb_mem_bist_arbiter.sv
// tb_mem_bist_arbiter: directed, table-driven bench for mem_bist_arbiter with a
// behavioural 1-cycle-latency memory
module tb_mem_bist_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 10;

  logic              clk;
  logic              rst_n;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              bist_req;
  logic [ADDR_W-1:0] bist_start_addr;
  logic [ADDR_W-1:0] bist_end_addr;
  logic [LEN_W-1:0]  bist_len;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_err;
  logic              runbist_en;
  logic              idle_en;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              bist_read_mem;
  logic [ADDR_W-1:0] bist_mem_addr;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic [DATA_W-1:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  mem_bist_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .bist_req(bist_req), .bist_start_addr(bist_start_addr),
    .bist_end_addr(bist_end_addr), .bist_len(bist_len),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_err(bist_err),
    .runbist_en(runbist_en), .idle_en(idle_en),
    .start_addr(start_addr), .end_addr(end_addr),
    .bist_read_mem(bist_read_mem), .bist_mem_addr(bist_mem_addr),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory, synchronous write and 1-cycle read latency
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= mem[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_gnt;
    logic       exp_mwe;
    logic       exp_mre;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bist_busy && k < 200) begin
      tick();
      k++;
    end
    check(name, {31'd0, bist_busy}, 32'd0);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d, input string name);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    check(name, {31'd0, host_gnt}, 32'd1);
    tick();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    tick();
    host_req = 1'b0;
    check({name, "_rvalid"}, {31'd0, host_rvalid}, 32'd1);
    check({name, "_rdata"}, {24'd0, host_rdata}, {24'd0, exp});
  endtask

  // Accept one session and watch it to completion
  task automatic session(input logic [7:0] s, input logic [7:0] e, input logic [9:0] len,
                         input int n, input string name);
    int first = 0, run = 0, busy = 0, dones = 0, donek = 0, win_ok = 1;
    logic err = 1'b1;
    bist_start_addr = s; bist_end_addr = e; bist_len = len; bist_req = 1'b1;
    tick();
    bist_req = 1'b0;
    bist_start_addr = ~s; bist_end_addr = ~e; bist_len = 10'd3;
    for (int k = 1; k <= n + 10; k++) begin
      if (runbist_en) begin
        run++;
        if (first == 0) first = k;
      end
      if (runbist_en !== idle_en) win_ok = 0;
      if (start_addr !== s || end_addr !== e) win_ok = 0;
      if (bist_busy) busy++;
      if (bist_done) begin
        dones++; donek = k; err = bist_err;
      end
      tick();
    end
    check({name, "_first_run"}, first, 2);
    check({name, "_run_cycles"}, run, n);
    check({name, "_busy_cycles"}, busy, n + 2);
    check({name, "_done_count"}, dones, 1);
    check({name, "_done_cycle"}, donek, n + 2);
    check({name, "_err"}, {31'd0, err}, 32'd0);
    check({name, "_window_held"}, win_ok, 1);
  endtask

  initial begin
    int k;
    int cnt;
    logic [5:0] busy_bits;
    logic [5:0] done_bits;

    rst_n = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    bist_req = 1'b0; bist_start_addr = '0; bist_end_addr = '0; bist_len = '0;
    bist_read_mem = 1'b0; bist_mem_addr = '0;

    tbl[0] = '{1'b1, 1'b1, 8'h10, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 8'h11, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C};
    tbl[3] = '{1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 8'h11, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81};
    tbl[5] = '{1'b0, 1'b1, 8'h10, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 8'h01, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A};

    // reset state
    tick(); tick();
    check("rst_runbist", {31'd0, runbist_en}, 32'd0);
    check("rst_idle_en", {31'd0, idle_en}, 32'd0);
    check("rst_busy", {31'd0, bist_busy}, 32'd0);
    check("rst_done", {31'd0, bist_done}, 32'd0);
    check("rst_err", {31'd0, bist_err}, 32'd0);
    check("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("rst_rdata", {24'd0, host_rdata}, 32'd0);
    check("rst_start", {24'd0, start_addr}, 32'd0);
    check("rst_end", {24'd0, end_addr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // host traffic in IDLE
    for (int i = 0; i < 8; i++) begin
      host_req = tbl[i].req; host_we = tbl[i].we;
      host_addr = tbl[i].addr; host_wdata = tbl[i].wdata;
      #1;
      check($sformatf("vec%0d_gnt", i), {31'd0, host_gnt}, {31'd0, tbl[i].exp_gnt});
      check($sformatf("vec%0d_mwe", i), {31'd0, mem_write_en}, {31'd0, tbl[i].exp_mwe});
      check($sformatf("vec%0d_mre", i), {31'd0, mem_read_en}, {31'd0, tbl[i].exp_mre});
      check($sformatf("vec%0d_maddr", i), {24'd0, mem_addr}, {24'd0, tbl[i].addr});
      check($sformatf("vec%0d_mwdata", i), {24'd0, mem_write_data}, {24'd0, tbl[i].wdata});
      tick();
      check($sformatf("vec%0d_rvalid", i), {31'd0, host_rvalid}, {31'd0, tbl[i].exp_rvalid});
      if (tbl[i].exp_rvalid)
        check($sformatf("vec%0d_rdata", i), {24'd0, host_rdata}, {24'd0, tbl[i].exp_rdata});
    end
    host_req = 1'b0; host_we = 1'b0;
    tick();

    // full sessions, including zero length and single-address window
    session(8'h00, 8'h02, 10'd50, 50, "basic");
    session(8'h00, 8'h03, 10'd0, 1, "len0");
    session(8'h05, 8'h05, 10'd3, 3, "win55");

    // host read colliding with acceptance, then a held write
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h01;
    bist_start_addr = 8'h00; bist_end_addr = 8'h02; bist_len = 10'd4; bist_req = 1'b1;
    #1;
    check("coll_gnt_accept", {31'd0, host_gnt}, 32'd1);
    tick();
    bist_req = 1'b0;
    check("coll_rvalid_drain", {31'd0, host_rvalid}, 32'd1);
    check("coll_rdata_drain", {24'd0, host_rdata}, 32'h5A);
    host_we = 1'b1; host_addr = 8'h02; host_wdata = 8'h77;
    #1;
    check("coll_drain_gnt", {31'd0, host_gnt}, 32'd0);
    check("coll_drain_mwe", {31'd0, mem_write_en}, 32'd0);
    check("coll_drain_mre", {31'd0, mem_read_en}, 32'd0);
    k = 1; cnt = 0;
    while (!host_gnt && k < 30) begin
      tick();
      k++;
      if (host_rvalid) cnt++;
    end
    check("coll_gnt_cycle", k, 7);
    check("coll_no_rvalid", cnt, 0);
    tick();
    host_req = 1'b0; host_we = 1'b0;
    host_read(8'h02, 8'h77, "coll_wr");

    // BIST owns the memory port
    bist_start_addr = 8'h00; bist_end_addr = 8'h02; bist_len = 10'd6; bist_req = 1'b1;
    tick();
    bist_req = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h80; host_wdata = 8'hFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      bist_read_mem = (i % 2 == 0);
      bist_mem_addr = (i % 2 == 0) ? 8'h02 : 8'(8'h40 + i);
      #1;
      check($sformatf("mux%0d_mre", i), {31'd0, mem_read_en}, {31'd0, bist_read_mem});
      check($sformatf("mux%0d_maddr", i), {24'd0, mem_addr}, {24'd0, bist_mem_addr});
      check($sformatf("mux%0d_mwe", i), {31'd0, mem_write_en}, 32'd0);
      check($sformatf("mux%0d_mwdata", i), {24'd0, mem_write_data}, 32'd0);
      check($sformatf("mux%0d_runbist", i), {31'd0, runbist_en}, 32'd1);
      check($sformatf("mux%0d_gnt", i), {31'd0, host_gnt}, 32'd0);
      tick();
      check($sformatf("mux%0d_rvalid", i), {31'd0, host_rvalid}, 32'd0);
    end
    bist_read_mem = 1'b0; host_req = 1'b0; host_we = 1'b0;
    wait_idle("mux_end_idle");
    tick();

    // inverted window is rejected
    bist_start_addr = 8'h06; bist_end_addr = 8'h02; bist_len = 10'd5; bist_req = 1'b1;
    tick();
    bist_req = 1'b0;
    check("rej_done", {31'd0, bist_done}, 32'd1);
    check("rej_err", {31'd0, bist_err}, 32'd1);
    check("rej_busy", {31'd0, bist_busy}, 32'd0);
    check("rej_runbist", {31'd0, runbist_en}, 32'd0);
    check("rej_start_kept", {24'd0, start_addr}, 32'h00);
    check("rej_end_kept", {24'd0, end_addr}, 32'h02);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h01;
    #1;
    check("rej_host_gnt", {31'd0, host_gnt}, 32'd1);
    tick();
    host_req = 1'b0;
    check("rej_done_clear", {31'd0, bist_done}, 32'd0);
    check("rej_err_clear", {31'd0, bist_err}, 32'd0);
    check("rej_host_rdata", {24'd0, host_rdata}, 32'h5A);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (runbist_en) cnt++;
      tick();
    end
    check("rej_no_runbist", cnt, 0);

    // request held across RELEASE starts the next session at once
    bist_start_addr = 8'h01; bist_end_addr = 8'h03; bist_len = 10'd2; bist_req = 1'b1;
    tick();
    busy_bits = '0; done_bits = '0;
    for (int i = 0; i < 6; i++) begin
      busy_bits[i] = bist_busy;
      done_bits[i] = bist_done;
      tick();
    end
    bist_req = 1'b0;
    check("b2b_busy_seq", {26'd0, busy_bits}, 32'b101111);
    check("b2b_done_seq", {26'd0, done_bits}, 32'b001000);
    wait_idle("b2b_end_idle");
    check("b2b_start", {24'd0, start_addr}, 32'h01);

    // reset in the middle of a session
    tick();
    bist_start_addr = 8'h01; bist_end_addr = 8'h02; bist_len = 10'd20; bist_req = 1'b1;
    tick();
    bist_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_runbist_before", {31'd0, runbist_en}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_runbist", {31'd0, runbist_en}, 32'd0);
    check("mid_rst_idle_en", {31'd0, idle_en}, 32'd0);
    check("mid_rst_busy", {31'd0, bist_busy}, 32'd0);
    check("mid_rst_done", {31'd0, bist_done}, 32'd0);
    check("mid_rst_start", {24'd0, start_addr}, 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bist_done || runbist_en) cnt++;
      tick();
    end
    check("mid_rst_quiet", cnt, 0);
    host_write(8'h03, 8'hA5, "post_rst_wr_gnt");
    host_read(8'h03, 8'hA5, "post_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
